serial_add_ctrl: RTL

Bit-serial adder sequencer that time-shares a single `FullAdder` cell across all bit positions of a WIDTH-bit add. It accepts a start request with two operands and a carry-in, then steps the full adder LSB-first, one bit per clock, through a carry flop. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the shared `FullAdder` instance, trading latency for area.

---
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: steps one shared full-adder cell LSB-first
// through a carry flop, returning {cout, sum} with a one-cycle done pulse.

module FullAdder (
    output logic Sout,
    output logic Cout,
    input  logic a,
    input  logic b,
    input  logic c
);
    assign Sout = a ^ b ^ c;
    assign Cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s, fa_c;
    logic             last;
    logic [WIDTH-1:0] s_shift;

    FullAdder u_fa (
        .Sout (fa_s),
        .Cout (fa_c),
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .c    (carry_q)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
    assign s_shift = (s_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last    = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == IDLE && start) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = s_shift;
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
                sum_d  = s_shift;
                cout_d = fa_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
